// File: rtl/router_pkg.sv
// Shared router definitions: port count, one-hot port codes, allocator states, credit depth.
package router_pkg;
  localparam int unsigned NPORT      = 5;
  localparam int unsigned CRED_DEPTH = 4;
  localparam int unsigned PTRW       = 3;

  localparam logic [NPORT-1:0] P0_OH = 5'b00001;
  localparam logic [NPORT-1:0] P1_OH = 5'b00010;
  localparam logic [NPORT-1:0] P2_OH = 5'b00100;
  localparam logic [NPORT-1:0] P3_OH = 5'b01000;
  localparam logic [NPORT-1:0] P4_OH = 5'b10000;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  function automatic logic [PTRW-1:0] oh_to_idx(input logic [NPORT-1:0] oh);
    logic [PTRW-1:0] idx;
    idx = '0;
    case (oh)
      P1_OH:   idx = 3'd1;
      P2_OH:   idx = 3'd2;
      P3_OH:   idx = 3'd3;
      P4_OH:   idx = 3'd4;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [PTRW-1:0] next_port(input logic [PTRW-1:0] idx);
    return (idx == PTRW'(NPORT - 1)) ? '0 : idx + PTRW'(1);
  endfunction
endpackage

// File: rtl/rr_arb5.sv
// Combinational round-robin arbiter: rotate by ptr, pick lowest set bit, rotate back.
module rr_arb5
  import router_pkg::*;
(
  input  logic [NPORT-1:0] elig,
  input  logic [PTRW-1:0]  ptr,
  output logic [NPORT-1:0] win
);
  logic [2*NPORT-1:0] rot_dbl;
  logic [2*NPORT-1:0] back_dbl;
  logic [NPORT-1:0]   rot;
  logic [NPORT-1:0]   rot_win;

  always_comb begin
    rot_dbl  = {elig, elig} >> ptr;
    rot      = rot_dbl[NPORT-1:0];
    rot_win  = rot & (~rot + NPORT'(1));
    back_dbl = {rot_win, rot_win} << ptr;
    win      = back_dbl[2*NPORT-1:NPORT];
  end
endmodule

// File: rtl/sw_alloc_out.sv
// Per-output switch allocator: packet-granular round-robin lock with downstream credit gating.
module sw_alloc_out #(
  parameter int unsigned NPORT      = router_pkg::NPORT,
  parameter int unsigned CRED_DEPTH = router_pkg::CRED_DEPTH,
  parameter int unsigned CW         = $clog2(CRED_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] head,
  input  logic [NPORT-1:0] tail,
  input  logic             credit_in,
  output logic [NPORT-1:0] grant,
  output logic             fire,
  output logic [CW-1:0]    credit_cnt,
  output logic             credit_err
);
  import router_pkg::*;

  state_e          state_q, state_d;
  logic [NPORT-1:0] grant_q, grant_d;
  logic [PTRW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    cred_q, cred_d;
  logic             err_q, err_d;

  logic [NPORT-1:0] elig;
  logic [NPORT-1:0] win;
  logic             cred_ok;
  logic             req_g;
  logic             tail_g;
  logic             fire_c;

  assign elig = req & head;

  rr_arb5 u_arb (
    .elig (elig),
    .ptr  (rr_ptr_q),
    .win  (win)
  );

  always_comb begin
    cred_ok  = (cred_q != '0);
    req_g    = |(req & grant_q);
    tail_g   = |(tail & grant_q);
    fire_c   = (state_q == LOCK) && req_g && cred_ok;

    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cred_d   = cred_q;
    err_d    = err_q;

    if (state_q == IDLE) begin
      if ((elig != '0) && cred_ok) begin
        grant_d = win;
        state_d = LOCK;
      end
    end else if (fire_c && tail_g) begin
      grant_d  = '0;
      state_d  = IDLE;
      rr_ptr_d = next_port(oh_to_idx(grant_q));
    end

    // A simultaneous fire and returned credit cancel, so neither the saturation check nor a decrement applies.
    if (fire_c && !credit_in) begin
      cred_d = cred_q - CW'(1);
    end else if (credit_in && !fire_c) begin
      if (cred_q == CW'(CRED_DEPTH)) err_d = 1'b1;
      else                           cred_d = cred_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cred_q   <= CW'(CRED_DEPTH);
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cred_q   <= cred_d;
      err_q    <= err_d;
    end
  end

  assign grant      = grant_q;
  assign fire       = fire_c;
  assign credit_cnt = cred_q;
  assign credit_err = err_q;
endmodule
